// File: rtl/dcache_wb.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_wb
//  Purpose  : Direct-mapped, write-back, write-allocate L1 data cache with
//             LL/SC link tracking and a halt-triggered dirty-block flush.
//             Optional build macro DCACHE_HITCOUNT_EN adds a hit/miss
//             counter.
//             - The counter increments on every completing request that is
//               not a failed SC, and decrements on every miss entry.
//             - Its value is written to address 0x3100 after the flush.
//  Revision : 1.0  initial release
// ============================================================================
module dcache_wb #(
    parameter int NSETS    = 16,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        datomic,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);
    localparam int IDXW = $clog2(NSETS);
    localparam int OFFW = $clog2(BLKWORDS);
    localparam int TAGW = 30 - OFFW - IDXW;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_WB0   = 4'd1,
        S_WB1   = 4'd2,
        S_LD0   = 4'd3,
        S_LD1   = 4'd4,
        S_FLUSH = 4'd5,
        S_FWB0  = 4'd6,
        S_FWB1  = 4'd7,
        S_DONE  = 4'd8
`ifdef DCACHE_HITCOUNT_EN
        , S_CNT = 4'd9
`endif
    } state_t;

    // Storage
    logic [31:0]      r_data [NSETS][BLKWORDS];
    logic [TAGW-1:0]  r_tag  [NSETS];
    logic [NSETS-1:0] r_valid;
    logic [NSETS-1:0] r_dirty;
    logic             r_link_valid;
    logic [29:0]      r_link_addr;
    logic [IDXW-1:0]  r_fidx;
    state_t           r_state;
    state_t           w_next;
`ifdef DCACHE_HITCOUNT_EN
    logic [31:0]      r_count;
`endif

    // Request decode
    logic [TAGW-1:0]  w_tag;
    logic [IDXW-1:0]  w_idx;
    logic [OFFW-1:0]  w_off;
    logic [29:0]      w_waddr;
    logic             w_hit;
    logic             w_link_match;
    logic             w_sc_fail;
    logic             w_vic_dirty;
    logic             w_fset_dirty;
    logic             w_last_set;
    logic             w_unused;

    // Datapath enables produced by the FSM
    logic             w_wr_hit;
    logic             w_ll_hit;
    logic             w_miss;
    logic             w_fill_we;
    logic [OFFW-1:0]  w_fill_word;
    logic             w_fill_done;
    logic             w_fset_clean;
    logic             w_fidx_inc;

    assign w_tag        = dmemaddr[31 -: TAGW];
    assign w_idx        = dmemaddr[2 + OFFW +: IDXW];
    assign w_off        = dmemaddr[2 +: OFFW];
    assign w_waddr      = dmemaddr[31:2];
    assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_link_match = r_link_valid && (r_link_addr == w_waddr);
    // An SC whose link is gone completes at once with result 0
    assign w_sc_fail    = dmemWEN && datomic && !w_link_match;
    assign w_vic_dirty  = r_valid[w_idx] && r_dirty[w_idx];
    assign w_fset_dirty = r_valid[r_fidx] && r_dirty[r_fidx];
    assign w_last_set   = (r_fidx == IDXW'(NSETS - 1));
    // Byte-offset bits carry no information for word accesses
    assign w_unused     = &{1'b0, dmemaddr[1:0]};

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, bus outputs and datapath enables
    always_comb begin
        w_next       = r_state;
        dhit         = 1'b0;
        dmemload     = '0;
        flushed      = 1'b0;
        dREN         = 1'b0;
        dWEN         = 1'b0;
        daddr        = '0;
        dstore       = '0;
        w_wr_hit     = 1'b0;
        w_ll_hit     = 1'b0;
        w_miss       = 1'b0;
        w_fill_we    = 1'b0;
        w_fill_word  = '0;
        w_fill_done  = 1'b0;
        w_fset_clean = 1'b0;
        w_fidx_inc   = 1'b0;
        // Outputs stay quiet while reset is held, even with a request present
        if (nRST) begin
            unique case (r_state)
                S_IDLE: begin
                    if (halt) begin
                        w_next = S_FLUSH;
                    end else if (dmemWEN) begin
                        if (w_sc_fail) begin
                            dhit = 1'b1;
                        end else if (w_hit) begin
                            dhit     = 1'b1;
                            w_wr_hit = 1'b1;
                            dmemload = {31'd0, datomic};
                        end else begin
                            w_miss = 1'b1;
                        end
                    end else if (dmemREN) begin
                        if (w_hit) begin
                            dhit     = 1'b1;
                            dmemload = r_data[w_idx][w_off];
                            w_ll_hit = datomic;
                        end else begin
                            w_miss = 1'b1;
                        end
                    end
                    if (w_miss) begin
                        w_next = w_vic_dirty ? S_WB0 : S_LD0;
                    end
                end
                S_WB0: begin
                    dWEN   = 1'b1;
                    daddr  = {r_tag[w_idx], w_idx, OFFW'(0), 2'b00};
                    dstore = r_data[w_idx][0];
                    if (!dwait) w_next = S_WB1;
                end
                S_WB1: begin
                    dWEN   = 1'b1;
                    daddr  = {r_tag[w_idx], w_idx, OFFW'(1), 2'b00};
                    dstore = r_data[w_idx][1];
                    if (!dwait) w_next = S_LD0;
                end
                S_LD0: begin
                    dREN  = 1'b1;
                    daddr = {w_tag, w_idx, OFFW'(0), 2'b00};
                    if (!dwait) begin
                        w_fill_we   = 1'b1;
                        w_fill_word = OFFW'(0);
                        w_next      = S_LD1;
                    end
                end
                S_LD1: begin
                    dREN  = 1'b1;
                    daddr = {w_tag, w_idx, OFFW'(1), 2'b00};
                    if (!dwait) begin
                        w_fill_we   = 1'b1;
                        w_fill_word = OFFW'(1);
                        w_fill_done = 1'b1;
                        w_next      = S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (w_fset_dirty) begin
                        w_next = S_FWB0;
                    end else if (w_last_set) begin
`ifdef DCACHE_HITCOUNT_EN
                        w_next = S_CNT;
`else
                        w_next = S_DONE;
`endif
                    end else begin
                        w_fidx_inc = 1'b1;
                    end
                end
                S_FWB0: begin
                    dWEN   = 1'b1;
                    daddr  = {r_tag[r_fidx], r_fidx, OFFW'(0), 2'b00};
                    dstore = r_data[r_fidx][0];
                    if (!dwait) w_next = S_FWB1;
                end
                S_FWB1: begin
                    dWEN   = 1'b1;
                    daddr  = {r_tag[r_fidx], r_fidx, OFFW'(1), 2'b00};
                    dstore = r_data[r_fidx][1];
                    // Return to FLUSH: the now-clean set is skipped there
                    if (!dwait) begin
                        w_fset_clean = 1'b1;
                        w_next       = S_FLUSH;
                    end
                end
`ifdef DCACHE_HITCOUNT_EN
                S_CNT: begin
                    dWEN   = 1'b1;
                    daddr  = 32'h0000_3100;
                    dstore = r_count;
                    if (!dwait) w_next = S_DONE;
                end
`endif
                S_DONE: begin
                    flushed = 1'b1;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    // Valid/dirty bits, link register and flush walk pointer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid      <= '0;
            r_dirty      <= '0;
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
            r_fidx       <= '0;
        end else begin
            if (w_wr_hit) begin
                r_dirty[w_idx] <= 1'b1;
                if (w_waddr == r_link_addr) r_link_valid <= 1'b0;
            end
            if (w_ll_hit) begin
                r_link_valid <= 1'b1;
                r_link_addr  <= w_waddr;
            end
            if (w_fill_done) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end
            if (w_fset_clean) r_dirty[r_fidx] <= 1'b0;
            if (w_fidx_inc)   r_fidx <= r_fidx + 1'b1;
        end
    end

    // Data and tag arrays (contents are don't-care until valid)
    always_ff @(posedge CLK) begin
        if (w_wr_hit)    r_data[w_idx][w_off]       <= dmemstore;
        if (w_fill_we)   r_data[w_idx][w_fill_word] <= dload;
        if (w_fill_done) r_tag[w_idx]               <= w_tag;
    end

`ifdef DCACHE_HITCOUNT_EN
    // Hit/miss balance counter reported at the end of the flush
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (dhit && !w_sc_fail) begin
            r_count <= r_count + 32'd1;
        end else if (w_miss) begin
            r_count <= r_count - 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_wb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_wb
//  Purpose  : Scoreboard bench for dcache_wb with a random-latency memory
//             and an architectural reference model of the cache.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dcache_wb;
    localparam int NSETS = 16;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        halt = 1'b0;
    logic        dmemREN = 1'b0;
    logic        dmemWEN = 1'b0;
    logic        datomic = 1'b0;
    logic [31:0] dmemaddr = '0;
    logic [31:0] dmemstore = '0;
    logic        dwait = 1'b0;
    logic [31:0] dload = '0;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    always #5 CLK = ~CLK;

    dcache_wb #(.NSETS(NSETS), .BLKWORDS(2)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload)
    );

    typedef struct { bit chk; logic [31:0] val; } hit_exp_t;
    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } mem_exp_t;

    int n_checks = 0;
    int n_fail   = 0;
    int hits_seen = 0;
    hit_exp_t exp_hit[$];
    mem_exp_t exp_mem[$];

    // Memory device contents and architectural (program-visible) memory
    logic [31:0] dev_mem  [logic [29:0]];
    logic [31:0] arch_mem [logic [29:0]];

    // Reference model of cache occupancy, link and hit counter
    bit          m_valid [NSETS];
    bit          m_dirty [NSETS];
    logic [24:0] m_tag   [NSETS];
    bit          m_lv;
    logic [29:0] m_la;
    logic [31:0] m_cnt;

    function automatic logic [31:0] init_val(logic [29:0] w);
        return {w[15:0], ~w[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] dev_rd(logic [29:0] w);
        if (dev_mem.exists(w)) return dev_mem[w];
        return init_val(w);
    endfunction

    function automatic logic [31:0] arch_rd(logic [29:0] w);
        if (arch_mem.exists(w)) return arch_mem[w];
        return init_val(w);
    endfunction

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic timeout(string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT, required completion", nm);
        finish_run();
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSETS; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        m_lv  = 1'b0;
        m_la  = '0;
        m_cnt = '0;
    endtask

    // Predict the response and memory traffic of one request
    task automatic model_req(bit ren, bit wen, bit at, logic [31:0] a, logic [31:0] d);
        logic [29:0] w;
        int          idx;
        logic [24:0] tg;
        hit_exp_t    h;
        mem_exp_t    e;
        w   = a[31:2];
        idx = int'(a[6:3]);
        tg  = a[31:7];
        if (wen && at && !(m_lv && m_la == w)) begin
            h.chk = 1'b1;
            h.val = 32'd0;
            exp_hit.push_back(h);
            return;
        end
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int k = 0; k < 2; k++) begin
                    e.wr   = 1'b1;
                    e.addr = {m_tag[idx], a[6:3], 1'(k), 2'b00};
                    e.data = arch_rd(e.addr[31:2]);
                    exp_mem.push_back(e);
                end
            end
            for (int k = 0; k < 2; k++) begin
                e.wr   = 1'b0;
                e.addr = {tg, a[6:3], 1'(k), 2'b00};
                e.data = '0;
                exp_mem.push_back(e);
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            m_cnt        = m_cnt - 32'd1;
        end
        m_cnt = m_cnt + 32'd1;
        if (wen) begin
            arch_mem[w]  = d;
            m_dirty[idx] = 1'b1;
            if (m_la == w) m_lv = 1'b0;
            h.chk = at;
            h.val = 32'd1;
        end else begin
            h.chk = 1'b1;
            h.val = arch_rd(w);
            if (at) begin
                m_lv = 1'b1;
                m_la = w;
            end
        end
        exp_hit.push_back(h);
    endtask

    // Expected flush traffic: dirty blocks in index order, then the counter
    task automatic push_flush_exp();
        mem_exp_t e;
        for (int i = 0; i < NSETS; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                for (int k = 0; k < 2; k++) begin
                    e.wr   = 1'b1;
                    e.addr = {m_tag[i], 4'(i), 1'(k), 2'b00};
                    e.data = arch_rd(e.addr[31:2]);
                    exp_mem.push_back(e);
                end
                m_dirty[i] = 1'b0;
            end
        end
`ifdef DCACHE_HITCOUNT_EN
        e.wr   = 1'b1;
        e.addr = 32'h0000_3100;
        e.data = m_cnt;
        exp_mem.push_back(e);
`endif
    endtask

    // Issue one request (called just after a rising edge) and hold until dhit
    task automatic do_req(bit ren, bit wen, bit at, logic [31:0] a, logic [31:0] d);
        int start;
        model_req(ren, wen, at, a, d);
        start     = hits_seen;
        dmemREN   = ren;
        dmemWEN   = wen;
        datomic   = at;
        dmemaddr  = a;
        dmemstore = d;
        for (int c = 0; c <= 200; c++) begin
            @(posedge CLK);
            if (hits_seen != start) break;
            if (c == 200) timeout("req_dhit");
        end
        #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        datomic = 1'b0;
    endtask

    task automatic do_flush();
        push_flush_exp();
        halt = 1'b1;
        for (int c = 0; c <= 3000; c++) begin
            @(negedge CLK);
            if (flushed) break;
            if (c == 3000) timeout("flush_done");
        end
        check("flushed", {31'd0, flushed}, 32'd1);
        check("flush_traffic_left", 32'(exp_mem.size()), 32'd0);
        check("flush_idle_dwen", {31'd0, dWEN}, 32'd0);
    endtask

    task automatic pulse_reset();
        #1 nRST = 1'b0;
        #1;
        check("rst_flushed", {31'd0, flushed}, 32'd0);
        check("rst_dwen", {31'd0, dWEN}, 32'd0);
        check("rst_dren", {31'd0, dREN}, 32'd0);
        check("rst_daddr", daddr, 32'd0);
        halt = 1'b0;
        model_reset();
        exp_hit.delete();
        exp_mem.delete();
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    // Memory device with random latency; also checks each completed transfer
    int  wait_left = 0;
    bit  in_xfer   = 1'b0;
    always @(negedge CLK) begin
        mem_exp_t e;
        if (!nRST) begin
            in_xfer = 1'b0;
            dwait   = 1'b0;
        end else if (dREN || dWEN) begin
            if (!in_xfer) begin
                in_xfer   = 1'b1;
                wait_left = int'($urandom_range(0, 2));
            end
            if (wait_left > 0) begin
                dwait = 1'b1;
                wait_left--;
            end else begin
                dwait   = 1'b0;
                in_xfer = 1'b0;
                if (dREN) dload = dev_rd(daddr[31:2]);
                else      dev_mem[daddr[31:2]] = dstore;
                if (exp_mem.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mem_unexpected: got %s at %h, required no transfer",
                             dWEN ? "write" : "read", daddr);
                end else begin
                    e = exp_mem.pop_front();
                    check("mem_is_write", {31'd0, dWEN}, {31'd0, e.wr});
                    check("mem_addr", daddr, e.addr);
                    if (e.wr) check("mem_wdata", dstore, e.data);
                end
            end
        end else begin
            in_xfer = 1'b0;
            dwait   = 1'b0;
        end
    end

    // Response monitor
    always @(negedge CLK) begin
        hit_exp_t h;
        if (nRST && dhit) begin
            if (exp_hit.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dhit_unexpected: got dhit=1 addr %h, required dhit=0", dmemaddr);
            end else begin
                h = exp_hit.pop_front();
                if (h.chk) check("dmemload", dmemload, h.val);
            end
            hits_seen++;
        end
    end

    initial begin
        logic [31:0] a;
        int          op;
        model_reset();
        dev_mem[30'h10]  = 32'h0000_000A;
        dev_mem[30'h11]  = 32'h0000_000B;
        arch_mem[30'h10] = 32'h0000_000A;
        arch_mem[30'h11] = 32'h0000_000B;

        #1;
        check("reset_dhit", {31'd0, dhit}, 32'd0);
        check("reset_dren", {31'd0, dREN}, 32'd0);
        check("reset_dwen", {31'd0, dWEN}, 32'd0);
        check("reset_flushed", {31'd0, flushed}, 32'd0);
        check("reset_daddr", daddr, 32'd0);
        check("reset_dstore", dstore, 32'd0);
        check("reset_dmemload", dmemload, 32'd0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // Directed scenarios
        do_req(1, 0, 0, 32'h0000_0040, 32'd0);
        do_req(1, 0, 0, 32'h0000_0044, 32'd0);
        do_req(0, 1, 0, 32'h0000_0040, 32'h0000_1234);
        do_req(1, 0, 0, 32'h0000_0840, 32'd0);
        do_req(1, 0, 1, 32'h0000_0080, 32'd0);
        do_req(0, 1, 1, 32'h0000_0080, 32'd5);
        do_req(1, 0, 0, 32'h0000_0080, 32'd0);
        do_req(1, 0, 1, 32'h0000_0080, 32'd0);
        do_req(0, 1, 0, 32'h0000_0080, 32'h0000_0077);
        do_req(0, 1, 1, 32'h0000_0080, 32'd9);
        do_req(0, 1, 1, 32'h0000_0084, 32'd3);
        do_req(1, 1, 0, 32'h0000_0088, 32'h0000_CAFE);
        do_req(1, 0, 0, 32'h0000_0088, 32'd0);

        // Random traffic over a small address pool to force conflicts
        for (int n = 0; n < 400; n++) begin
            a  = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 3)
               | (32'($urandom_range(0, 1)) << 2);
            op = int'($urandom_range(0, 9));
            if (op <= 3)      do_req(1, 0, 0, a, 32'd0);
            else if (op <= 6) do_req(0, 1, 0, a, $urandom);
            else if (op == 7) begin
                do_req(1, 0, 1, a, 32'd0);
                do_req(0, 1, 1, a, $urandom);
            end
            else if (op == 8) do_req(0, 1, 1, a, $urandom);
            else              do_req(1, 1, 0, a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
        end

        do_flush();
        pulse_reset();

        // Only sets 0 and 5 dirty; sets 2 and 5 also touched by reads
        do_req(0, 1, 0, 32'h0000_0000, 32'h1111_0000);
        do_req(0, 1, 0, 32'h0000_0028, 32'h5555_0005);
        do_req(1, 0, 0, 32'h0000_0010, 32'd0);
        do_req(1, 0, 0, 32'h0000_002C, 32'd0);
        do_flush();
        pulse_reset();

        // Reset while the first flush writeback is on the bus
        do_req(0, 1, 0, 32'h0000_0018, 32'h3333_0003);
        push_flush_exp();
        halt = 1'b1;
        for (int c = 0; c <= 100; c++) begin
            @(negedge CLK);
            if (dWEN) break;
            if (c == 100) timeout("fwb0_start");
        end
        #1 nRST = 1'b0;
        #1;
        check("midflush_rst_dwen", {31'd0, dWEN}, 32'd0);
        check("midflush_rst_flushed", {31'd0, flushed}, 32'd0);
        check("midflush_rst_daddr", daddr, 32'd0);
        check("midflush_rst_dstore", dstore, 32'd0);

        finish_run();
    end
endmodule
`default_nettype wire
